// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency, pipelined main memory between the
// I-cache fill path and the D-cache fill/store path. D has priority over I.
// Fills stream BLOCK_WORDS consecutive word reads. Returned words are tagged
// by a valid/index shift register that is MEM_LAT deep. D writes are posted
// single-word stores.
module mem_arbiter #(
  parameter int MEM_LAT     = 4,
  parameter int BLOCK_WORDS = 8,
  parameter int IDX_W       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req,
  input  logic [15:0]      i_addr,
  output logic             i_fill_valid,
  output logic [IDX_W-1:0] i_fill_idx,
  output logic             i_done,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [15:0]      d_addr,
  input  logic [15:0]      d_wdata,
  output logic             d_fill_valid,
  output logic [IDX_W-1:0] d_fill_idx,
  output logic             d_done,
  output logic [15:0]      fill_data,
  output logic             mem_en,
  output logic             mem_wr,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  // Clears the word offset inside a block; the block base never wraps.
  localparam logic [15:0]      BASE_MASK = ~16'(2 * BLOCK_WORDS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BLOCK_WORDS - 1);

  state_t           state;
  logic             owner_d;
  logic [IDX_W-1:0] issue_idx;

  logic             pipe_valid [MEM_LAT];
  logic [IDX_W-1:0] pipe_idx   [MEM_LAT];

  logic             ret_valid;
  logic [IDX_W-1:0] ret_idx;
  logic             ret_last;

  assign ret_valid = pipe_valid[MEM_LAT-1];
  assign ret_idx   = pipe_idx[MEM_LAT-1];
  assign ret_last  = ret_valid && (ret_idx == LAST_IDX);

  // Arbitration, address issue and state sequencing, all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      issue_idx <= '0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (d_req) begin
            if (d_we) begin
              state     <= WRITE;
              mem_en    <= 1'b1;
              mem_wr    <= 1'b1;
              mem_addr  <= d_addr & 16'hFFFE;
              mem_wdata <= d_wdata;
            end else begin
              state     <= FILL;
              owner_d   <= 1'b1;
              issue_idx <= '0;
              mem_en    <= 1'b1;
              mem_addr  <= d_addr & BASE_MASK;
            end
          end else if (i_req) begin
            state     <= FILL;
            owner_d   <= 1'b0;
            issue_idx <= '0;
            mem_en    <= 1'b1;
            mem_addr  <= i_addr & BASE_MASK;
          end
        end
        FILL: begin
          if (mem_en) begin
            if (issue_idx == LAST_IDX) begin
              mem_en   <= 1'b0;
              mem_addr <= 16'h0000;
            end else begin
              issue_idx <= issue_idx + IDX_W'(1);
              mem_addr  <= mem_addr + 16'd2;
            end
          end
          if (ret_last) begin
            state <= IDLE;
          end
        end
        WRITE: begin
          state     <= IDLE;
          mem_en    <= 1'b0;
          mem_wr    <= 1'b0;
          mem_addr  <= 16'h0000;
          mem_wdata <= 16'h0000;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Tags each issued read so its word index pops out when its data returns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < MEM_LAT; s++) begin
        pipe_valid[s] <= 1'b0;
        pipe_idx[s]   <= '0;
      end
    end else begin
      pipe_valid[0] <= mem_en & ~mem_wr;
      pipe_idx[0]   <= issue_idx;
      for (int s = 1; s < MEM_LAT; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_idx[s]   <= pipe_idx[s-1];
      end
    end
  end

  assign i_fill_valid = ret_valid & ~owner_d;
  assign d_fill_valid = ret_valid & owner_d;
  assign i_fill_idx   = i_fill_valid ? ret_idx : '0;
  assign d_fill_idx   = d_fill_valid ? ret_idx : '0;
  assign fill_data    = ret_valid ? mem_rdata : 16'h0000;
  assign i_done       = ret_last & ~owner_d;
  assign d_done       = (ret_last & owner_d) | (state == WRITE);
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against an
// expected per-cycle trace derived from block-fill and posted-write timing.
// The memory model returns a seeded function of the address after MEM_LAT.
module tb_mem_arbiter;

  localparam int MEM_LAT = 4;
  localparam int BW      = 8;
  localparam int IDX_W   = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_req;
  logic [15:0]      i_addr;
  logic             i_fill_valid;
  logic [IDX_W-1:0] i_fill_idx;
  logic             i_done;
  logic             d_req;
  logic             d_we;
  logic [15:0]      d_addr;
  logic [15:0]      d_wdata;
  logic             d_fill_valid;
  logic [IDX_W-1:0] d_fill_idx;
  logic             d_done;
  logic [15:0]      fill_data;
  logic             mem_en;
  logic             mem_wr;
  logic [15:0]      mem_addr;
  logic [15:0]      mem_wdata;
  logic [15:0]      mem_rdata;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem_seed = 16'h1234;
  logic [15:0] rd_pipe [MEM_LAT];

  mem_arbiter #(
    .MEM_LAT    (MEM_LAT),
    .BLOCK_WORDS(BW),
    .IDX_W      (IDX_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_fill_valid(i_fill_valid),
    .i_fill_idx  (i_fill_idx),
    .i_done      (i_done),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_fill_valid(d_fill_valid),
    .d_fill_idx  (d_fill_idx),
    .d_done      (d_done),
    .fill_data   (fill_data),
    .mem_en      (mem_en),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .busy        (busy)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Contents of main memory: a seeded scramble of the byte address
  function automatic logic [15:0] word_at(input logic [15:0] a);
    logic [31:0] t;
    t = {16'd0, a} * 32'd40503;
    return t[15:0] ^ mem_seed;
  endfunction

  function automatic logic [15:0] block_base(input logic [15:0] a);
    return a - (a % 16'(2 * BW));
  endfunction

  // Fixed-latency memory: read data appears MEM_LAT cycles after issue,
  // and unrelated garbage is driven in every other cycle. It is never reset.
  always @(posedge clk) begin
    rd_pipe[0] <= (mem_en && !mem_wr) ? word_at(mem_addr) : 16'($urandom);
    for (int s = 1; s < MEM_LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
  end
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  // Hard time limit so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, ".mem_en"},       16'(mem_en),       16'h0);
    check_output({tag, ".mem_wr"},       16'(mem_wr),       16'h0);
    check_output({tag, ".mem_addr"},     mem_addr,          16'h0);
    check_output({tag, ".mem_wdata"},    mem_wdata,         16'h0);
    check_output({tag, ".i_fill_valid"}, 16'(i_fill_valid), 16'h0);
    check_output({tag, ".d_fill_valid"}, 16'(d_fill_valid), 16'h0);
    check_output({tag, ".i_fill_idx"},   16'(i_fill_idx),   16'h0);
    check_output({tag, ".d_fill_idx"},   16'(d_fill_idx),   16'h0);
    check_output({tag, ".fill_data"},    fill_data,         16'h0);
    check_output({tag, ".i_done"},       16'(i_done),       16'h0);
    check_output({tag, ".d_done"},       16'(d_done),       16'h0);
    check_output({tag, ".busy"},         16'(busy),         16'h0);
  endtask

  // Called at the negedge of the accept cycle with the request driven; ends
  // at the negedge of the done cycle with the owner's request dropped.
  task automatic expect_fill(input bit is_d, input logic [15:0] req_addr);
    logic [15:0] base;
    logic [15:0] exp_addr;
    logic [15:0] exp_data;
    logic        exp_en;
    logic        exp_fv;
    logic        own_v, oth_v, own_done, oth_done;
    logic [IDX_W-1:0] own_idx;
    int          total;
    int          k;
    base  = block_base(req_addr);
    total = BW + MEM_LAT;
    check_idle("fill_accept");
    @(posedge clk);
    #1;
    if (is_d) begin
      d_addr  = 16'($urandom);
      d_wdata = 16'($urandom);
      d_we    = 1'($urandom);
    end else begin
      i_addr = 16'($urandom);
    end
    for (int n = 1; n <= total; n++) begin
      @(negedge clk);
      k        = n - 1 - MEM_LAT;
      exp_en   = (n <= BW);
      exp_addr = exp_en ? 16'(base + 16'(2 * (n - 1))) : 16'h0000;
      exp_fv   = (k >= 0) && (k < BW);
      exp_data = exp_fv ? word_at(16'(base + 16'(2 * k))) : 16'h0000;
      own_v    = is_d ? d_fill_valid : i_fill_valid;
      oth_v    = is_d ? i_fill_valid : d_fill_valid;
      own_idx  = is_d ? d_fill_idx   : i_fill_idx;
      own_done = is_d ? d_done       : i_done;
      oth_done = is_d ? i_done       : d_done;
      check_output("fill.mem_en",     16'(mem_en),   16'(exp_en));
      check_output("fill.mem_wr",     16'(mem_wr),   16'h0);
      check_output("fill.mem_addr",   mem_addr,      exp_addr);
      check_output("fill.mem_wdata",  mem_wdata,     16'h0);
      check_output("fill.busy",       16'(busy),     16'h1);
      check_output("fill.own_valid",  16'(own_v),    16'(exp_fv));
      check_output("fill.own_idx",    16'(own_idx),  exp_fv ? 16'(k) : 16'h0);
      check_output("fill.other_valid",16'(oth_v),    16'h0);
      check_output("fill.fill_data",  fill_data,     exp_data);
      check_output("fill.own_done",   16'(own_done), 16'(n == total));
      check_output("fill.other_done", 16'(oth_done), 16'h0);
      if (n == total) begin
        if (is_d) d_req = 1'b0;
        else      i_req = 1'b0;
      end
    end
  endtask

  // Called at the negedge of the accept cycle; ends at the negedge of the
  // write cycle with d_req dropped.
  task automatic expect_write(input logic [15:0] req_addr, input logic [15:0] req_data);
    check_idle("wr_accept");
    @(posedge clk);
    #1;
    d_addr  = 16'($urandom);
    d_wdata = 16'($urandom);
    @(negedge clk);
    check_output("wr.mem_en",       16'(mem_en),       16'h1);
    check_output("wr.mem_wr",       16'(mem_wr),       16'h1);
    check_output("wr.mem_addr",     mem_addr,          req_addr - (req_addr % 16'd2));
    check_output("wr.mem_wdata",    mem_wdata,         req_data);
    check_output("wr.d_done",       16'(d_done),       16'h1);
    check_output("wr.i_done",       16'(i_done),       16'h0);
    check_output("wr.busy",         16'(busy),         16'h1);
    check_output("wr.i_fill_valid", 16'(i_fill_valid), 16'h0);
    check_output("wr.d_fill_valid", 16'(d_fill_valid), 16'h0);
    check_output("wr.fill_data",    fill_data,         16'h0);
    d_req = 1'b0;
  endtask

  // Directed scenarios followed by randomized operation mixes
  initial begin
    int          kind;
    logic [15:0] ia, da, dw;

    mem_seed = 16'($urandom);
    rst_n   = 1'b0;
    i_req   = 1'b0;
    i_addr  = 16'h0000;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = 16'h0000;
    d_wdata = 16'h0000;

    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      i_req   = 1'($urandom);
      i_addr  = 16'($urandom);
      d_req   = 1'($urandom);
      d_we    = 1'($urandom);
      d_addr  = 16'($urandom);
      d_wdata = 16'($urandom);
      #1;
      check_idle("in_reset");
    end
    @(negedge clk);
    i_req = 1'b0;
    d_req = 1'b0;
    d_we  = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_idle("after_reset");
    end

    $display("[TB] I fill 0x0136");
    @(negedge clk);
    i_addr = 16'h0136;
    i_req  = 1'b1;
    expect_fill(1'b0, 16'h0136);
    @(negedge clk);
    check_idle("i_fill_end");

    $display("[TB] simultaneous I 0x0040 / D read 0x2008");
    @(negedge clk);
    i_addr = 16'h0040;
    i_req  = 1'b1;
    d_addr = 16'h2008;
    d_we   = 1'b0;
    d_req  = 1'b1;
    expect_fill(1'b1, 16'h2008);
    @(negedge clk);
    expect_fill(1'b0, 16'h0040);
    @(negedge clk);
    check_idle("simul_end");

    $display("[TB] D write 0x3002");
    @(negedge clk);
    d_addr  = 16'h3002;
    d_wdata = 16'hBEEF;
    d_we    = 1'b1;
    d_req   = 1'b1;
    expect_write(16'h3002, 16'hBEEF);
    @(negedge clk);
    check_idle("write_end");

    $display("[TB] top-of-memory block 0xFFFA");
    @(negedge clk);
    i_addr = 16'hFFFA;
    i_req  = 1'b1;
    expect_fill(1'b0, 16'hFFFA);
    @(negedge clk);
    check_idle("top_end");

    $display("[TB] reset in the middle of an I fill");
    @(negedge clk);
    i_addr = 16'h0A10;
    i_req  = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 6; n++) @(negedge clk);
    rst_n = 1'b0;
    i_req = 1'b0;
    #1;
    check_idle("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check_idle("aborted_fill");
    end
    ia = 16'($urandom);
    i_addr = ia;
    i_req  = 1'b1;
    expect_fill(1'b0, ia);
    @(negedge clk);
    check_idle("refill_end");

    $display("[TB] randomized operations");
    for (int it = 0; it < 24; it++) begin
      kind = int'($urandom_range(0, 4));
      ia   = 16'($urandom);
      da   = 16'($urandom);
      dw   = 16'($urandom);
      @(negedge clk);
      case (kind)
        0: begin
          i_addr = ia; i_req = 1'b1;
          expect_fill(1'b0, ia);
        end
        1: begin
          d_addr = da; d_we = 1'b0; d_req = 1'b1;
          expect_fill(1'b1, da);
        end
        2: begin
          d_addr = da; d_wdata = dw; d_we = 1'b1; d_req = 1'b1;
          expect_write(da, dw);
        end
        3: begin
          i_addr = ia; i_req = 1'b1;
          d_addr = da; d_we = 1'b0; d_req = 1'b1;
          expect_fill(1'b1, da);
          @(negedge clk);
          expect_fill(1'b0, ia);
        end
        default: begin
          i_addr = ia; i_req = 1'b1;
          d_addr = da; d_wdata = dw; d_we = 1'b1; d_req = 1'b1;
          expect_write(da, dw);
          @(negedge clk);
          expect_fill(1'b0, ia);
        end
      endcase
      @(negedge clk);
      check_idle("rand_end");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
